muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 23 ++
 rtl/muldiv_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response handshake bundle between a pipeline front end and muldiv_unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_src1;
  logic [WIDTH-1:0] req_src2;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_src1, req_src2, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit: iterative restoring divider, shift-add or
// single-cycle multiplier (define MULDIV_FAST_MUL_EN for the combinational product).
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  muldiv_unit_if.slave     bus,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MFHI  = 3'b110;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] stage_hi;
  logic [WIDTH-1:0] stage_lo;
  logic             wr_hi;
  logic             wr_lo;
  logic             rsp_valid_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic             accept;
  logic             src1_neg;
  logic             src2_neg;
  logic [WIDTH-1:0] src1_mag;
  logic [WIDTH-1:0] src2_mag;

  assign bus.req_ready = (state == S_IDLE) && resetn;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign hi_out        = hi_reg;
  assign lo_out        = lo_reg;

  // Even opcodes (MULT, DIV) are the signed ones; arithmetic runs on magnitudes.
  assign accept   = bus.req_valid && bus.req_ready && !cancel;
  assign src1_neg = !bus.req_op[0] && bus.req_src1[WIDTH-1];
  assign src2_neg = !bus.req_op[0] && bus.req_src2[WIDTH-1];
  assign src1_mag = src1_neg ? -bus.req_src1 : bus.req_src1;
  assign src2_mag = src2_neg ? -bus.req_src2 : bus.req_src2;

  // Restoring divide step: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] mul_sum;
  assign rem_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, opb};
  assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opa : {WIDTH{1'b0}})};

  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  assign prod_mag = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod_mag : prod_mag;
  assign quo_fix  = neg_q ? -acc_lo : acc_lo;
  assign rem_fix  = neg_r ? -acc_hi : acc_hi;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_mag;
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_mag  = {{WIDTH{1'b0}}, src1_mag} * {{WIDTH{1'b0}}, src2_mag};
  assign fast_prod = (src1_neg ^ src2_neg) ? -fast_mag : fast_mag;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      count         <= '0;
      is_div        <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      div_zero      <= 1'b0;
      opa           <= '0;
      opb           <= '0;
      acc_hi        <= '0;
      acc_lo        <= '0;
      stage_hi      <= '0;
      stage_lo      <= '0;
      wr_hi         <= 1'b0;
      wr_lo         <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            count        <= '0;
            is_div       <= bus.req_op[1];
            neg_q        <= src1_neg ^ src2_neg;
            neg_r        <= src1_neg;
            div_zero     <= (bus.req_src2 == '0);
            acc_hi       <= '0;
            wr_hi        <= 1'b0;
            wr_lo        <= 1'b0;
            rsp_data_reg <= '0;
            case (bus.req_op)
              OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                {stage_hi, stage_lo} <= fast_prod;
                wr_hi         <= 1'b1;
                wr_lo         <= 1'b1;
                rsp_valid_reg <= 1'b1;
                state         <= S_DONE;
`else
                opa    <= src1_mag;
                acc_lo <= src2_mag;
                state  <= S_MUL;
`endif
              end
              OP_DIV, OP_DIVU: begin
                // opa keeps the raw dividend for the divide-by-zero result
                opa    <= bus.req_src1;
                opb    <= src2_mag;
                acc_lo <= src1_mag;
                state  <= S_DIV;
              end
              OP_MTHI: begin
                stage_hi      <= bus.req_src1;
                wr_hi         <= 1'b1;
                rsp_valid_reg <= 1'b1;
                state         <= S_DONE;
              end
              OP_MTLO: begin
                stage_lo      <= bus.req_src1;
                wr_lo         <= 1'b1;
                rsp_valid_reg <= 1'b1;
                state         <= S_DONE;
              end
              OP_MFHI: begin
                rsp_data_reg  <= hi_reg;
                rsp_valid_reg <= 1'b1;
                state         <= S_DONE;
              end
              default: begin
                rsp_data_reg  <= lo_reg;
                rsp_valid_reg <= 1'b1;
                state         <= S_DONE;
              end
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (cancel) begin
            count <= '0;
            state <= S_IDLE;
          end else begin
            if (state == S_MUL) begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end else if (!trial[WIDTH]) begin
              acc_hi <= trial[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= rem_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
            if (count == LAST_STEP) begin
              count <= '0;
              state <= S_FIX;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        S_FIX: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            if (!is_div) begin
              {stage_hi, stage_lo} <= prod_fix;
            end else if (div_zero) begin
              stage_hi <= opa;
              stage_lo <= '1;
            end else begin
              stage_hi <= rem_fix;
              stage_lo <= quo_fix;
            end
            wr_hi         <= 1'b1;
            wr_lo         <= 1'b1;
            rsp_valid_reg <= 1'b1;
            state         <= S_DONE;
          end
        end
        S_DONE: begin
          // cancel wins over a same-cycle handshake, so nothing commits
          if (cancel || bus.rsp_ready) begin
            if (!cancel && wr_hi) hi_reg <= stage_hi;
            if (!cancel && wr_lo) lo_reg <= stage_lo;
            wr_hi         <= 1'b0;
            wr_lo         <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors queue expectations, a monitor checks responses.
module tb_muldiv_unit;
  localparam int WIDTH   = 32;
  localparam int DIV_LAT = WIDTH + 2;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = WIDTH + 2;
`endif

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MFHI  = 3'b110;
  localparam logic [2:0] OP_MFLO  = 3'b111;

  logic             clk    = 1'b0;
  logic             resetn = 1'b0;
  logic             cancel = 1'b0;
  logic             cancel8 = 1'b0;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic [7:0]       hi8;
  logic [7:0]       lo8;

  muldiv_unit_if #(.WIDTH(WIDTH)) bus ();
  muldiv_unit_if #(.WIDTH(8))     bus8 ();

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .cancel(cancel), .hi_out(hi_out), .lo_out(lo_out)
  );
  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .bus(bus8), .cancel(cancel8), .hi_out(hi8), .lo_out(lo8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat_v;
    int          lat_hs;
    int          acc;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input bit push, input logic [31:0] d, input logic [31:0] h,
                       input logic [31:0] l, input int lv, input int lh);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: req_ready got 0 expected 1");
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_src1  = s1;
    bus.req_src2  = s2;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (push) begin
      e.data = d; e.hi = h; e.lo = l; e.lat_v = lv; e.lat_hs = lh; e.acc = cyc;
      sbq.push_back(e);
    end
    $display("issue op=%0d src1=%h src2=%h", op, s1, s2);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending got %0d expected 0", sbq.size());
    end
  endtask

  // Monitor: compares every presented response against the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    int   first_cyc;
    bit   seen;
    seen = 1'b0;
    first_cyc = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        seen = 1'b0;
      end else if (bus.rsp_valid) begin
        if (!seen) begin
          seen = 1'b1;
          first_cyc = cyc;
        end
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid got 1 expected 0 data=%h", bus.rsp_data);
        end else begin
          e = sbq[0];
          chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
          if (bus.rsp_ready) begin
            void'(sbq.pop_front());
            seen = 1'b0;
            chk("valid_latency", 64'(first_cyc - e.acc + 1), 64'(e.lat_v));
            chk("handshake_latency", 64'(cyc - e.acc + 1), 64'(e.lat_hs));
            @(negedge clk);
            chk("hi_commit", 64'(hi_out), 64'(e.hi));
            chk("lo_commit", 64'(lo_out), 64'(e.lo));
            $display("rsp data=%h hi=%h lo=%h", e.data, hi_out, lo_out);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int n;
    int acc;
    bus.req_valid = 1'b0; bus.req_op = 3'b000; bus.req_src1 = '0; bus.req_src2 = '0;
    bus.rsp_ready = 1'b1;
    bus8.req_valid = 1'b0; bus8.req_op = 3'b000; bus8.req_src1 = '0; bus8.req_src2 = '0;
    bus8.rsp_ready = 1'b1;

    #2;
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("reset_hi", 64'(hi_out), 64'd0);
    chk("reset_lo", 64'(lo_out), 64'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    issue(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT, DIV_LAT);
    issue(OP_DIVU,  32'h00000064, 32'h00000000, 1, 32'h0, 32'h00000064, 32'hFFFFFFFF, DIV_LAT, DIV_LAT);
    issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h00000000, 32'h80000000, DIV_LAT, DIV_LAT);
    issue(OP_MULT,  32'hFFFFFFFF, 32'h00000002, 1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, MUL_LAT);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 1, 32'h0, 32'h00000001, 32'hFFFFFFFE, MUL_LAT, MUL_LAT);
    issue(OP_DIV,   32'h00000064, 32'h00000007, 1, 32'h0, 32'h00000002, 32'h0000000E, DIV_LAT, DIV_LAT);
    issue(OP_DIV,   32'hFFFFFF9C, 32'h00000007, 1, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFF2, DIV_LAT, DIV_LAT);
    issue(OP_MULT,  32'hFFFFFFFD, 32'h00000007, 1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL_LAT, MUL_LAT);
    issue(OP_MULTU, 32'h80000000, 32'h00000004, 1, 32'h0, 32'h00000002, 32'h00000000, MUL_LAT, MUL_LAT);
    issue(OP_MTHI,  32'h12345678, 32'h0,        1, 32'h0, 32'h12345678, 32'h00000000, 1, 1);
    issue(OP_MTLO,  32'hCAFEF00D, 32'h0,        1, 32'h0, 32'h12345678, 32'hCAFEF00D, 1, 1);

    // MFHI held off by a consumer stalled for five cycles
    drain();
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    issue(OP_MFHI, 32'h0, 32'h0, 1, 32'h12345678, 32'h12345678, 32'hCAFEF00D, 1, 6);
    repeat (5) @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    issue(OP_MFLO,  32'h0,        32'h0,        1, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D, 1, 1);
    issue(OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 1, 32'h0, 32'h0000000F, 32'h0FFFFFFF, DIV_LAT, DIV_LAT);
    drain();

    // Cancel an in-flight divide at cycle 10
    issue(OP_DIV, 32'h00000064, 32'h00000007, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    chk("cancel_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("cancel_req_ready", 64'(bus.req_ready), 64'd1);
    chk("cancel_hi", 64'(hi_out), 64'h0000000F);
    chk("cancel_lo", 64'(lo_out), 64'h0FFFFFFF);
    repeat (40) @(negedge clk);
    chk("cancel_hi_late", 64'(hi_out), 64'h0000000F);

    // Cancel in IDLE blocks acceptance
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_MTHI; bus.req_src1 = 32'hDEADBEEF; cancel = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("idle_cancel_ready", 64'(bus.req_ready), 64'd1);
    chk("idle_cancel_valid", 64'(bus.rsp_valid), 64'd0);
    repeat (3) @(negedge clk);
    chk("idle_cancel_hi", 64'(hi_out), 64'h0000000F);

    // Reset pulsed mid-divide
    issue(OP_DIV, 32'h00000064, 32'h00000007, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    repeat (9) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("midreset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("midreset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midreset_hi", 64'(hi_out), 64'd0);
    chk("midreset_lo", 64'(lo_out), 64'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("postreset_req_ready", 64'(bus.req_ready), 64'd1);
    repeat (40) @(negedge clk);
    chk("postreset_hi", 64'(hi_out), 64'd0);
    chk("postreset_lo", 64'(lo_out), 64'd0);

    // 8-bit instance: DIVU 0xFF / 0x10
    @(negedge clk);
    bus8.req_valid = 1'b1; bus8.req_op = OP_DIVU; bus8.req_src1 = 8'hFF; bus8.req_src2 = 8'h10;
    @(posedge clk);
    #1 acc = cyc;
    bus8.req_valid = 1'b0;
    $display("issue w8 op=%0d src1=ff src2=10", OP_DIVU);
    n = 0;
    @(negedge clk);
    while (!bus8.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("w8_valid_latency", 64'(cyc - acc + 1), 64'd10);
    chk("w8_rsp_data", 64'(bus8.rsp_data), 64'd0);
    @(negedge clk);
    chk("w8_lo", 64'(lo8), 64'h0F);
    chk("w8_hi", 64'(hi8), 64'h0F);
    $display("rsp w8 hi=%h lo=%h", hi8, lo8);

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
